axi_burst_master: RTL and testbench
===================================

Name: axi_burst_master

Overview:
- AXI-style burst initiator; the bus-side counterpart of axi_ram.
- Accepts one read or write command at a time on a simple command port and drives the AW/W/B or AR/R channels.
- Streams write data in from a local source and read data out to a local sink.
- Reports completion with a one-cycle done pulse and a response code.

Parameters:
ADDR_WIDTH, 16, address width of command and AWADDR/ARADDR
DATA_WIDTH, 32, data width of WDATA/RDATA and local streams

Ports:
ACLK  in  1  clock, all logic rising-edge
ARESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when both high
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  ADDR_WIDTH  start address
cmd_len  in  8  beat count (number of beats, not minus one)
cmd_burst  in  1  1=incrementing, 0=fixed; forwarded unchanged
wr_valid  in  1  local write data valid
wr_ready  out  1  local write data consumed
wr_data  in  DATA_WIDTH  local write data
rd_valid  out  1  local read data valid
rd_ready  in  1  local sink ready
rd_data  out  DATA_WIDTH  read data
rd_last  out  1  final read beat
done  out  1  one-cycle pulse at command completion
resp  out  2  completion response, valid with done, held until next done
busy  out  1  high whenever FSM not IDLE
AWVALID out 1; AWREADY in 1; AWADDR out ADDR_WIDTH; AWBURST out 1; AWLEN out 8
WVALID out 1; WREADY in 1; WDATA out DATA_WIDTH; WLAST out 1
BVALID in 1; BREADY out 1; BRESP in 2
ARVALID out 1; ARREADY in 1; ARADDR out ADDR_WIDTH; ARBURST out 1; ARLEN out 8
RVALID in 1; RREADY out 1; RDATA in DATA_WIDTH; RRESP in 2; RLAST in 1

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; every output 0, including cmd_ready, resp, AW*/AR* fields, done and busy. Reset mid-burst abandons the burst immediately with no done pulse.
- States: IDLE, AW, W, B, AR, R, DONE.
- IDLE: cmd_ready=1.
  - cmd_valid&cmd_write -> AW; cmd_valid&!cmd_write -> AR. Addr, len and burst are registered on acceptance.
  - cmd_len=0 -> DONE with resp=2'b10; no bus activity.
- AW: AWVALID=1 starting the cycle after acceptance. AWADDR/AWBURST/AWLEN are stable while AWVALID=1.
  - On the edge sampling AWVALID&AWREADY -> W; AWVALID, AWADDR, AWBURST and AWLEN return to 0 next cycle.
- W: combinational pass-through: WVALID=wr_valid, WDATA=wr_data, wr_ready=WREADY.
  - 8-bit beat counter increments on WVALID&WREADY. WLAST=(count==len-1) while in W.
  - After the handshake with WLAST=1 -> B. WVALID, WDATA and WLAST are 0 outside W.
- B: BREADY=1. On BVALID, BRESP is captured into resp -> DONE.
- AR: mirror of AW using ARVALID/ARADDR/ARBURST/ARLEN; on handshake -> R.
- R: pass-through: rd_valid=RVALID, rd_data=RDATA, RREADY=rd_ready, rd_last=(count==len-1).
  - Counter increments on RVALID&RREADY.
  - resp accumulates the maximum RRESP seen over the burst.
  - If RLAST disagrees with the expected last beat on any handshake, resp is forced to 2'b10.
  - After the len-th handshake -> DONE, regardless of RLAST.
- DONE: done=1 for exactly one cycle -> IDLE. cmd_ready=0 during DONE, so back-to-back commands have a minimum one-cycle gap.
- Minimum write latency, acceptance to done with an always-ready slave: 1 (AW) + len (W) + 1 (B) + 1 (DONE) cycles.
- Counter width is 8 bits; len=255 is the maximum burst and must not overflow.
- Address increment is the slave's job; the block never modifies the start address.
- Simultaneous cmd_valid while busy: ignored, since cmd_ready=0.
- wr_valid low mid-burst: WVALID drops and the counter holds; no bubble beats are inserted.

Test Plan:
- Write cmd addr=0x0005, len=10, burst=1, wr_data 0x5..0xE, against axi_ram -> AWADDR=0x0005, AWLEN=10 for one handshake; 10 W beats; WLAST only on data 0xE; done pulse; resp=BRESP.
- Read cmd addr=0x0005, len=10 after the write -> rd_data 0x5..0xE in order; rd_last only on 0xE; done once; busy falls the cycle after done.
- Backpressure: random WREADY/rd_ready and wr_valid gaps on a len=10 burst -> no lost or duplicated beats; count=10; AWADDR stable while AWVALID&!AWREADY.
- len=1 write and read -> WLAST=1 / rd_last=1 on the first beat; write latency acceptance-to-done = 4 cycles with an always-ready slave.
- cmd_len=0 -> no AWVALID/ARVALID ever; done after 1 cycle with resp=2'b10.
- ARESETn low after beat 4 of a 10-beat write -> all outputs 0 asynchronously; no done; a new 2-beat command after release completes normally.

Source files
------------

// File: rtl/axi_burst_master.sv
// axi_burst_master: single-outstanding AXI-style burst initiator.
// A local command port launches one read or write burst at a time. Write
// data streams straight from the local source onto W, and read data streams
// straight from R to the local sink. Completion is a one-cycle done pulse
// with a response code that is held until the next completion.
module axi_burst_master #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    // command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic                  cmd_burst,
    // local write source
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    // local read sink
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    // status
    output logic                  done,
    output logic [1:0]            resp,
    output logic                  busy,
    // write address channel
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic                  AWBURST,
    output logic [7:0]            AWLEN,
    // write data channel
    output logic                  WVALID,
    input  logic                  WREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WLAST,
    // write response channel
    input  logic                  BVALID,
    output logic                  BREADY,
    input  logic [1:0]            BRESP,
    // read address channel
    output logic                  ARVALID,
    input  logic                  ARREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic                  ARBURST,
    output logic [7:0]            ARLEN,
    // read data channel
    input  logic                  RVALID,
    output logic                  RREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST
);

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic                  burst_q;
    logic [7:0]            count;
    logic [1:0]            resp_acc, resp_acc_next;
    logic                  last_err, last_err_next;
    logic                  accept, last_beat, w_hs, r_hs;

    // cmd_ready is registered so it is low while reset is held and during DONE
    assign accept    = (state == S_IDLE) && cmd_valid && cmd_ready;
    assign last_beat = (count == len_q - 8'd1);
    assign w_hs      = (state == S_W) && wr_valid && WREADY;
    assign r_hs      = (state == S_R) && RVALID && rd_ready;
    assign busy      = (state != S_IDLE);

    // Next-state logic, channel outputs and response accumulation
    always_comb begin
        // NOTE: every signal written here gets a default first so no path can
        // leave it unassigned; a missing default would infer a latch.
        next_state    = state;
        resp_acc_next = resp_acc;
        last_err_next = last_err;
        AWVALID  = 1'b0;  AWADDR  = '0;  AWBURST = 1'b0;  AWLEN = 8'd0;
        ARVALID  = 1'b0;  ARADDR  = '0;  ARBURST = 1'b0;  ARLEN = 8'd0;
        WVALID   = 1'b0;  WDATA   = '0;  WLAST   = 1'b0;  wr_ready = 1'b0;
        BREADY   = 1'b0;  RREADY  = 1'b0;
        rd_valid = 1'b0;  rd_data = '0;  rd_last = 1'b0;
        done     = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    resp_acc_next = 2'b00;
                    last_err_next = 1'b0;
                    if (cmd_len == 8'd0) begin
                        // empty burst: no bus traffic, report an error
                        resp_acc_next = 2'b10;
                        next_state    = S_DONE;
                    end else begin
                        next_state = cmd_write ? S_AW : S_AR;
                    end
                end
            end
            S_AW: begin
                AWVALID = 1'b1;
                AWADDR  = addr_q;
                AWBURST = burst_q;
                AWLEN   = len_q;
                if (AWREADY) next_state = S_W;
            end
            S_W: begin
                WVALID   = wr_valid;
                WDATA    = wr_data;
                wr_ready = WREADY;
                WLAST    = last_beat;
                if (w_hs && last_beat) next_state = S_B;
            end
            S_B: begin
                BREADY = 1'b1;
                if (BVALID) begin
                    resp_acc_next = BRESP;
                    next_state    = S_DONE;
                end
            end
            S_AR: begin
                ARVALID = 1'b1;
                ARADDR  = addr_q;
                ARBURST = burst_q;
                ARLEN   = len_q;
                if (ARREADY) next_state = S_R;
            end
            S_R: begin
                rd_valid = RVALID;
                rd_data  = RDATA;
                RREADY   = rd_ready;
                rd_last  = last_beat;
                if (r_hs) begin
                    if (RRESP > resp_acc) resp_acc_next = RRESP;
                    // a slave RLAST that disagrees with our beat count is sticky
                    if (RLAST != last_beat) last_err_next = 1'b1;
                    // the beat count, not RLAST, ends the burst
                    if (last_beat) next_state = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // State, command fields, beat counter and the held completion response
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b0;
            addr_q    <= '0;
            len_q     <= 8'd0;
            burst_q   <= 1'b0;
            count     <= 8'd0;
            resp_acc  <= 2'b00;
            last_err  <= 1'b0;
            resp      <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // the pre-edge values, independent of statement order.
            state     <= next_state;
            cmd_ready <= (next_state == S_IDLE);
            resp_acc  <= resp_acc_next;
            last_err  <= last_err_next;
            if (accept) begin
                addr_q  <= cmd_addr;
                len_q   <= cmd_len;
                burst_q <= cmd_burst;
                count   <= 8'd0;
            end else if (w_hs || r_hs) begin
                // never passes len-1, so len=255 cannot wrap
                count <= count + 8'd1;
            end
            if (next_state == S_DONE)
                resp <= last_err_next ? 2'b10 : resp_acc_next;
        end
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: directed bench for axi_burst_master.
// A behavioural AXI slave (memory, configurable stalls) and a local
// source/sink surround the DUT. Tests queue their expected AW/AR fields,
// W beats, read beats and completion codes; a monitor pops and compares
// whenever the DUT presents a handshake or a done pulse.
module tb_axi_burst_master;

    localparam int AW_W = 16;
    localparam int DW   = 32;

    logic            ACLK = 1'b0;
    logic            ARESETn;
    logic            cmd_valid, cmd_ready, cmd_write, cmd_burst;
    logic [AW_W-1:0] cmd_addr;
    logic [7:0]      cmd_len;
    logic            wr_valid, wr_ready;
    logic [DW-1:0]   wr_data;
    logic            rd_valid, rd_ready, rd_last;
    logic [DW-1:0]   rd_data;
    logic            done, busy;
    logic [1:0]      resp;
    logic            AWVALID, AWREADY, AWBURST;
    logic [AW_W-1:0] AWADDR;
    logic [7:0]      AWLEN;
    logic            WVALID, WREADY, WLAST;
    logic [DW-1:0]   WDATA;
    logic            BVALID, BREADY;
    logic [1:0]      BRESP;
    logic            ARVALID, ARREADY, ARBURST;
    logic [AW_W-1:0] ARADDR;
    logic [7:0]      ARLEN;
    logic            RVALID, RREADY, RLAST;
    logic [DW-1:0]   RDATA;
    logic [1:0]      RRESP;

    always #5 ACLK = ~ACLK;

    axi_burst_master #(.ADDR_WIDTH(AW_W), .DATA_WIDTH(DW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_burst(cmd_burst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .resp(resp), .busy(busy),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWBURST(AWBURST), .AWLEN(AWLEN),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARBURST(ARBURST), .ARLEN(ARLEN),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST)
    );

    typedef struct packed {
        logic [AW_W-1:0] addr;
        logic [7:0]      len;
        logic            burst;
    } addr_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    // scoreboard queues
    addr_t      exp_aw[$], exp_ar[$];
    beat_t      exp_w[$], exp_rd[$];
    logic [1:0] exp_done[$];
    logic [DW-1:0] wr_q[$];

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    int w_hs_cnt = 0, rd_hs_cnt = 0, done_cnt = 0, awvalid_cnt = 0, arvalid_cnt = 0;

    // slave model configuration
    int         aw_delay = 0;
    bit         wready_rand = 0, rvalid_rand = 0, wgap_rand = 0, rdrdy_rand = 0;
    logic [1:0] bresp_val = 2'b00;
    logic [1:0] rresp_tbl [0:255] = '{default: 2'b00};
    int         rlast_bad_beat = -1;

    always @(posedge ACLK) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural AXI slave ----------------
    initial begin : slave
        logic [DW-1:0] mem [0:255];
        logic [7:0]    wptr = 8'd0, rptr = 8'd0;
        logic          wb = 1'b0, rb = 1'b0;
        bit            b_pend = 0, r_active = 0;
        int            rbeat = 0, rlen = 0, aw_cnt = 0, ar_cnt = 0;
        bit            aw_hs, aw_seen, w_hs, b_hs, ar_hs, ar_seen, r_hs;
        logic [AW_W-1:0] awaddr_s, araddr_s;
        logic          awburst_s, arburst_s, wlast_s;
        logic [7:0]    arlen_s;
        logic [DW-1:0] wdata_s;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0;
        forever begin
            @(negedge ACLK);
            aw_hs = AWVALID && AWREADY;  aw_seen = AWVALID;
            w_hs  = WVALID && WREADY;    b_hs = BVALID && BREADY;
            ar_hs = ARVALID && ARREADY;  ar_seen = ARVALID;
            r_hs  = RVALID && RREADY;
            awaddr_s = AWADDR; awburst_s = AWBURST; wdata_s = WDATA; wlast_s = WLAST;
            araddr_s = ARADDR; arburst_s = ARBURST; arlen_s = ARLEN;
            @(posedge ACLK); #1;
            if (!ARESETn) begin
                b_pend = 0; r_active = 0; aw_cnt = 0; ar_cnt = 0; rbeat = 0;
            end else begin
                if (aw_hs) begin
                    wptr = awaddr_s[7:0]; wb = awburst_s; aw_cnt = 0;
                end else if (aw_seen) aw_cnt++;
                if (b_hs) b_pend = 0;
                if (w_hs) begin
                    mem[wptr] = wdata_s;
                    if (wb) wptr++;
                    if (wlast_s) b_pend = 1;
                end
                if (ar_hs) begin
                    rptr = araddr_s[7:0]; rb = arburst_s; rlen = int'(arlen_s);
                    rbeat = 0; r_active = (arlen_s != 8'd0); ar_cnt = 0;
                end else if (ar_seen) ar_cnt++;
                if (r_hs) begin
                    rbeat++;
                    if (rb) rptr++;
                    if (rbeat == rlen) r_active = 0;
                end
            end
            AWREADY = (aw_cnt >= aw_delay);
            ARREADY = (ar_cnt >= aw_delay);
            WREADY  = wready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            BVALID  = b_pend;
            BRESP   = b_pend ? bresp_val : 2'b00;
            // once RVALID is up it stays up until the beat is taken
            if (!r_active) RVALID = 1'b0;
            else if (!(RVALID && !r_hs))
                RVALID = rvalid_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            RDATA = mem[rptr];
            RRESP = rresp_tbl[rbeat[7:0]];
            RLAST = r_active && ((rbeat == rlen - 1) != (rbeat == rlast_bad_beat));
        end
    end

    // ---------------- local write source and read sink ----------------
    initial begin : local_side
        bit wr_hs_s;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        forever begin
            @(negedge ACLK);
            wr_hs_s = wr_valid && wr_ready;
            @(posedge ACLK); #1;
            if (wr_hs_s && wr_q.size() > 0) void'(wr_q.pop_front());
            if (wr_q.size() > 0) begin
                wr_valid = wgap_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
                wr_data  = wr_q[0];
            end else begin
                wr_valid = 1'b0;
                wr_data  = '0;
            end
            rd_ready = rdrdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        addr_t a;
        beat_t b;
        forever begin
            @(negedge ACLK);
            if (AWVALID) begin
                awvalid_cnt++;
                if (exp_aw.size() == 0) check("aw_unexpected", 64'(AWVALID), 64'(0));
                else begin
                    a = exp_aw[0];
                    if (!AWREADY) check("awaddr_stable", 64'(AWADDR), 64'(a.addr));
                    else begin
                        void'(exp_aw.pop_front());
                        check("awaddr", 64'(AWADDR), 64'(a.addr));
                        check("awlen", 64'(AWLEN), 64'(a.len));
                        check("awburst", 64'(AWBURST), 64'(a.burst));
                    end
                end
            end
            if (ARVALID) begin
                arvalid_cnt++;
                if (exp_ar.size() == 0) check("ar_unexpected", 64'(ARVALID), 64'(0));
                else begin
                    a = exp_ar[0];
                    if (!ARREADY) check("araddr_stable", 64'(ARADDR), 64'(a.addr));
                    else begin
                        void'(exp_ar.pop_front());
                        check("araddr", 64'(ARADDR), 64'(a.addr));
                        check("arlen", 64'(ARLEN), 64'(a.len));
                        check("arburst", 64'(ARBURST), 64'(a.burst));
                    end
                end
            end
            if (WVALID && WREADY) begin
                w_hs_cnt++;
                if (exp_w.size() == 0) check("w_unexpected", 64'(WVALID), 64'(0));
                else begin
                    b = exp_w.pop_front();
                    check("wdata", 64'(WDATA), 64'(b.data));
                    check("wlast", 64'(WLAST), 64'(b.last));
                end
            end
            if (rd_valid && rd_ready) begin
                rd_hs_cnt++;
                if (exp_rd.size() == 0) check("rd_unexpected", 64'(rd_valid), 64'(0));
                else begin
                    b = exp_rd.pop_front();
                    check("rd_data", 64'(rd_data), 64'(b.data));
                    check("rd_last", 64'(rd_last), 64'(b.last));
                end
            end
            if (done) begin
                done_cnt++;
                if (exp_done.size() == 0) check("done_unexpected", 64'(done), 64'(0));
                else check("resp", 64'(resp), 64'(exp_done.pop_front()));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic expect_addr(input bit wr, input logic [AW_W-1:0] addr,
                               input logic [7:0] len, input logic burst);
        addr_t a;
        a.addr = addr; a.len = len; a.burst = burst;
        if (wr) exp_aw.push_back(a);
        else    exp_ar.push_back(a);
    endtask

    task automatic expect_beat(input bit wr, input logic [DW-1:0] data, input logic last);
        beat_t b;
        b.data = data; b.last = last;
        if (wr) begin
            exp_w.push_back(b);
            wr_q.push_back(data);
        end else begin
            exp_rd.push_back(b);
        end
    endtask

    // present a command until accepted; returns the cycle of acceptance
    task automatic issue(input bit wr, input logic [AW_W-1:0] addr, input logic [7:0] len,
                         input logic burst, output int acc_cyc);
        int n = 0;
        @(posedge ACLK); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_burst = burst;
        @(negedge ACLK);
        while (!cmd_ready && n < 50) begin
            n++;
            @(negedge ACLK);
        end
        if (!cmd_ready) check("cmd_accept_timeout", 64'(cmd_ready), 64'(1));
        acc_cyc = cyc;
        @(posedge ACLK); #1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = 8'd0; cmd_burst = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int done_cyc);
        int n = 0;
        done_cyc = -1;
        while (n < budget && done_cyc < 0) begin
            @(negedge ACLK);
            if (done) done_cyc = cyc;
            n++;
        end
        if (done_cyc < 0) check("done_timeout", 64'(done), 64'(1));
    endtask

    // full command: queue expectations, issue, wait, check drain and busy drop
    task automatic run_cmd(input string tag, input bit wr, input logic [AW_W-1:0] addr,
                           input logic [7:0] len, input logic burst, input logic [DW-1:0] first,
                           input bit incr_data, input logic [1:0] exp_resp, output int lat);
        int acc, dc, d0;
        d0 = done_cnt;
        if (len != 8'd0) expect_addr(wr, addr, len, burst);
        for (int i = 0; i < int'(len); i++)
            expect_beat(wr, incr_data ? first + DW'(i) : first, i == int'(len) - 1);
        exp_done.push_back(exp_resp);
        issue(wr, addr, len, burst, acc);
        wait_done(2000, dc);
        lat = dc - acc;
        @(negedge ACLK);
        check({tag, "_busy_after_done"}, 64'({busy, done}), 64'(0));
        check({tag, "_done_once"}, 64'(done_cnt - d0), 64'(1));
        check({tag, "_drained"}, 64'(exp_aw.size() + exp_ar.size() + exp_w.size()
                                     + exp_rd.size() + exp_done.size()), 64'(0));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, 64'({cmd_ready, busy, done, resp, AWVALID, WVALID, WLAST, wr_ready,
                                   BREADY, ARVALID, RREADY, rd_valid, rd_last}), 64'(0));
        check({tag, "_aw"}, 64'({AWADDR, AWLEN, AWBURST}), 64'(0));
        check({tag, "_ar"}, 64'({ARADDR, ARLEN, ARBURST}), 64'(0));
        check({tag, "_data"}, {WDATA, rd_data}, 64'(0));
    endtask

    // ---------------- directed tests ----------------
    initial begin : main
        int lat, n, base, d0, aw0, ar0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = 8'd0; cmd_burst = 1'b0;
        ARESETn = 1'b1;
        #1 ARESETn = 1'b0;
        #1 check_outputs_zero("reset");
        repeat (2) @(posedge ACLK);
        #1 ARESETn = 1'b1;
        repeat (2) @(negedge ACLK);
        check("idle_cmd_ready", 64'(cmd_ready), 64'(1));

        // 1: 10-beat incrementing write, always-ready slave, BRESP=EXOKAY
        bresp_val = 2'b01;
        run_cmd("wr10", 1'b1, 16'h0005, 8'd10, 1'b1, 32'h5, 1'b1, 2'b01, lat);
        check("wr10_latency", 64'(lat), 64'(13));

        // 2: read the same burst back
        run_cmd("rd10", 1'b0, 16'h0005, 8'd10, 1'b1, 32'h5, 1'b1, 2'b00, lat);

        // 3: backpressure on every channel, then read back with one EXOKAY beat
        bresp_val = 2'b00; aw_delay = 3;
        wready_rand = 1; wgap_rand = 1; rdrdy_rand = 1; rvalid_rand = 1;
        base = w_hs_cnt;
        run_cmd("bp_wr", 1'b1, 16'h0020, 8'd10, 1'b1, 32'hA0, 1'b1, 2'b00, lat);
        check("bp_wr_beats", 64'(w_hs_cnt - base), 64'(10));
        rresp_tbl[3] = 2'b01;
        base = rd_hs_cnt;
        run_cmd("bp_rd", 1'b0, 16'h0020, 8'd10, 1'b1, 32'hA0, 1'b1, 2'b01, lat);
        check("bp_rd_beats", 64'(rd_hs_cnt - base), 64'(10));
        rresp_tbl[3] = 2'b00; aw_delay = 0;
        wready_rand = 0; wgap_rand = 0; rdrdy_rand = 0; rvalid_rand = 0;

        // 4: single-beat write and read
        run_cmd("wr1", 1'b1, 16'h0040, 8'd1, 1'b1, 32'hDEADBEEF, 1'b1, 2'b00, lat);
        check("wr1_latency", 64'(lat), 64'(4));
        run_cmd("rd1", 1'b0, 16'h0040, 8'd1, 1'b1, 32'hDEADBEEF, 1'b1, 2'b00, lat);

        // 5: zero-length commands never touch the bus
        aw0 = awvalid_cnt; ar0 = arvalid_cnt;
        run_cmd("wr0", 1'b1, 16'h0100, 8'd0, 1'b1, 32'h0, 1'b1, 2'b10, lat);
        check("wr0_latency", 64'(lat), 64'(1));
        run_cmd("rd0", 1'b0, 16'h0100, 8'd0, 1'b1, 32'h0, 1'b1, 2'b10, lat);
        check("rd0_latency", 64'(lat), 64'(1));
        check("len0_no_addr_valid", 64'((awvalid_cnt - aw0) + (arvalid_cnt - ar0)), 64'(0));

        // 6: fixed-burst read with an early RLAST from the slave
        rlast_bad_beat = 1;
        run_cmd("rd_fixed_badlast", 1'b0, 16'h0005, 8'd4, 1'b0, 32'h5, 1'b0, 2'b10, lat);
        rlast_bad_beat = -1;

        // 7: reset after beat 4 of a 10-beat write, then a clean 2-beat write
        expect_addr(1'b1, 16'h0060, 8'd10, 1'b1);
        for (int i = 0; i < 10; i++) expect_beat(1'b1, 32'h60 + DW'(i), i == 9);
        base = w_hs_cnt;
        issue(1'b1, 16'h0060, 8'd10, 1'b1, n);
        n = 0;
        while (w_hs_cnt - base < 4 && n < 200) begin
            @(posedge ACLK); #1;
            n++;
        end
        check("rst_beats_before_reset", 64'(w_hs_cnt - base), 64'(4));
        d0 = done_cnt;
        ARESETn = 1'b0;
        #1 check_outputs_zero("midburst_reset");
        exp_aw.delete(); exp_w.delete(); wr_q.delete();
        repeat (3) @(posedge ACLK);
        #1 ARESETn = 1'b1;
        check("rst_no_done", 64'(done_cnt - d0), 64'(0));
        bresp_val = 2'b01;
        run_cmd("post_rst_wr2", 1'b1, 16'h0070, 8'd2, 1'b1, 32'h11, 1'b1, 2'b01, lat);
        check("post_rst_wr2_latency", 64'(lat), 64'(5));

        repeat (3) @(negedge ACLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
